// File: rtl/alu_mem_unit.sv
// Accumulator-CPU datapath core: word-addressed data memory whose read port feeds ALU operand B.
// Optional feature: define ALU_SUB_EN to make opcode 12 compute A-B instead of passing A through.
module alu_mem_unit #(
    parameter int N     = 16,
    parameter int DEPTH = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] mem_addr,
    input  logic [N-1:0] mem_wdata,
    input  logic         mem_we,
    output logic [N-1:0] mem_rdata,
    input  logic [N-1:0] alu_a,
    input  logic [3:0]   opcode,
    output logic [N-1:0] alu_result,
    output logic [N-1:0] alu_result_q
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(N);
    localparam logic [N-1:0] SHIFT_LIMIT = N'(N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_XOR = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_SEQ = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SL  = 4'd6;
    localparam logic [3:0] OP_SR  = 4'd7;
`ifdef ALU_SUB_EN
    localparam logic [3:0] OP_SUB = 4'd12;
`endif

    // Every word must clear on reset, so the array lives in flops rather than a RAM macro.
    logic [N-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] addr_idx;
    logic [N-1:0]  b_val;
    logic [N-1:0]  alu_next;
    logic          shift_oob;

    assign addr_idx  = mem_addr[AW-1:0];
    assign mem_rdata = mem_reg[addr_idx];
    assign b_val     = mem_rdata;
    assign shift_oob = (b_val >= SHIFT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (mem_we) begin
            mem_reg[addr_idx] <= mem_wdata;
        end
    end

    always_comb begin
        alu_next = alu_a;
        case (opcode)
            OP_ADD: alu_next = alu_a + b_val;
            OP_XOR: alu_next = alu_a ^ b_val;
            OP_OR:  alu_next = alu_a | b_val;
            OP_AND: alu_next = alu_a & b_val;
            OP_SEQ: alu_next = {{(N-1){1'b0}}, (alu_a == b_val)};
            OP_SLT: alu_next = {{(N-1){1'b0}}, (alu_a < b_val)};
            OP_SL:  alu_next = shift_oob ? '0 : (alu_a << b_val[SW-1:0]);
            OP_SR:  alu_next = shift_oob ? '0 : (alu_a >> b_val[SW-1:0]);
`ifdef ALU_SUB_EN
            OP_SUB: alu_next = alu_a - b_val;
`endif
            default: alu_next = alu_a;
        endcase
    end

    assign alu_result = alu_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
        end else begin
            alu_result_q <= alu_next;
        end
    end

endmodule

// File: tb/tb_alu_mem_unit.sv
// Directed self-checking bench for alu_mem_unit: reset, memory write/alias, ALU ops and the registered result.
module tb_alu_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] alu_a = '0;
    logic [3:0]  opcode = '0;
    logic [15:0] alu_result;
    logic [15:0] alu_result_q;

    int total = 0;
    int bad   = 0;

    alu_mem_unit #(.N(16), .DEPTH(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .alu_a        (alu_a),
        .opcode       (opcode),
        .alu_result   (alu_result),
        .alu_result_q (alu_result_q)
    );

    always #5 clk = ~clk;

    task automatic mem_write(input logic [15:0] addr, input logic [15:0] data);
        mem_addr  = addr;
        mem_wdata = data;
        mem_we    = 1'b1;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        $display("write addr=%h data=%h", addr, data);
    endtask

    task automatic test_reset;
        mem_write(16'h0005, 16'h1234);
        mem_addr = 16'h0005;
        #1;
        total++;
        if (mem_rdata !== 16'h1234) begin
            bad++;
            $display("FAIL pre_reset_read got=%h want=%h", mem_rdata, 16'h1234);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL async_clear got=%h want=%h", mem_rdata, 16'h0000);
        end
        total++;
        if (alu_result_q !== 16'h0000) begin
            bad++;
            $display("FAIL async_q_clear got=%h want=%h", alu_result_q, 16'h0000);
        end
        // A write attempted while held in reset must be dropped.
        mem_addr  = 16'h0005;
        mem_wdata = 16'hBEEF;
        mem_we    = 1'b1;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        rst_n  = 1'b1;
        #1;
        total++;
        if (mem_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL reset_read got=%h want=%h", mem_rdata, 16'h0000);
        end
        total++;
        if (alu_result_q !== 16'h0000) begin
            bad++;
            $display("FAIL reset_q got=%h want=%h", alu_result_q, 16'h0000);
        end
        $display("reset: rdata=%h q=%h", mem_rdata, alu_result_q);
    endtask

    task automatic test_write_alias;
        mem_write(16'h0003, 16'h00FF);
        mem_addr = 16'h0003;
        #1;
        total++;
        if (mem_rdata !== 16'h00FF) begin
            bad++;
            $display("FAIL read_addr3 got=%h want=%h", mem_rdata, 16'h00FF);
        end
        mem_addr = 16'h0403;
        #1;
        total++;
        if (mem_rdata !== 16'h00FF) begin
            bad++;
            $display("FAIL alias_0403 got=%h want=%h", mem_rdata, 16'h00FF);
        end
        mem_addr  = 16'h0003;
        mem_wdata = 16'hAAAA;
        mem_we    = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (mem_rdata !== 16'h00FF) begin
            bad++;
            $display("FAIL we_low_hold got=%h want=%h", mem_rdata, 16'h00FF);
        end
        // Read-during-write: old value before the edge, ALU sees pre-edge B, new value after.
        mem_addr  = 16'h0007;
        mem_wdata = 16'h5555;
        mem_we    = 1'b1;
        alu_a     = 16'h0001;
        opcode    = 4'd0;
        #1;
        total++;
        if (mem_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL rdw_old got=%h want=%h", mem_rdata, 16'h0000);
        end
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        total++;
        if (mem_rdata !== 16'h5555) begin
            bad++;
            $display("FAIL rdw_new got=%h want=%h", mem_rdata, 16'h5555);
        end
        total++;
        if (alu_result_q !== 16'h0001) begin
            bad++;
            $display("FAIL rdw_q_pre_edge got=%h want=%h", alu_result_q, 16'h0001);
        end
        $display("write/alias: rdata=%h q=%h", mem_rdata, alu_result_q);
    endtask

    task automatic test_arith_logic;
        logic [3:0]  ops [4];
        logic [15:0] exp_v [4];
        ops   = '{4'd0, 4'd1, 4'd2, 4'd3};
        exp_v = '{16'h0000, 16'hFFFE, 16'hFFFF, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            alu_a    = 16'hFF01;
            mem_addr = 16'h0003;
            opcode   = ops[i];
            #1;
            total++;
            if (alu_result !== exp_v[i]) begin
                bad++;
                $display("FAIL alu_op%0d got=%h want=%h", ops[i], alu_result, exp_v[i]);
            end
            @(posedge clk);
            #1;
            total++;
            if (alu_result_q !== exp_v[i]) begin
                bad++;
                $display("FAIL alu_q_op%0d got=%h want=%h", ops[i], alu_result_q, exp_v[i]);
            end
            $display("op=%0d a=%h b=%h result=%h q=%h", ops[i], alu_a, mem_rdata, alu_result, alu_result_q);
        end
    endtask

    task automatic test_cmp_shift_pass;
        logic [3:0]  ops   [15];
        logic [15:0] as    [15];
        logic [15:0] addrs [15];
        logic [15:0] exp_v [15];
        logic [15:0] sub_exp;
`ifdef ALU_SUB_EN
        sub_exp = 16'hFFFE;
`else
        sub_exp = 16'h0007;
`endif
        mem_write(16'h000A, 16'hFFFF);
        mem_write(16'h000B, 16'h0001);
        mem_write(16'h000C, 16'h0004);
        mem_write(16'h000D, 16'h0010);
        mem_write(16'h000E, 16'h0009);
        mem_write(16'h000F, 16'h000F);
        ops   = '{4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7,
                  4'd12, 4'd9, 4'd15, 4'd0};
        as    = '{16'h00FF, 16'h00FE, 16'h0001, 16'hFFFF, 16'h00FF, 16'h8001, 16'h8001,
                  16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h0007, 16'h0007, 16'h0007,
                  16'hFFFF};
        addrs = '{16'h0003, 16'h0003, 16'h000A, 16'h000B, 16'h0003, 16'h000C, 16'h000C,
                  16'h000D, 16'h000D, 16'h000F, 16'h000F, 16'h000E, 16'h000E, 16'h000E,
                  16'h000B};
        exp_v = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0010, 16'h0800,
                  16'h0000, 16'h0000, 16'h8000, 16'h0001, sub_exp, 16'h0007, 16'h0007,
                  16'h0000};
        for (int i = 0; i < 15; i++) begin
            alu_a    = as[i];
            mem_addr = addrs[i];
            opcode   = ops[i];
            #1;
            total++;
            if (alu_result !== exp_v[i]) begin
                bad++;
                $display("FAIL vec%0d_op%0d got=%h want=%h", i, ops[i], alu_result, exp_v[i]);
            end
            $display("op=%0d a=%h b=%h result=%h", ops[i], alu_a, mem_rdata, alu_result);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_alias();
        test_arith_logic();
        test_cmp_shift_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
